// File: rtl/sat_counter_table_if.sv
// rtl/sat_counter_table_if.sv - read/update/flush bundle for the saturating counter table
interface sat_counter_table_if #(
    parameter int WIDTH = 2,
    parameter int IDX_W = 4
);
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_count;
    logic             rd_msb;
    logic             up_en;
    logic [IDX_W-1:0] up_idx;
    logic             count_up;
    logic             count_down;
    logic             flush;
    logic             busy;
    logic             sat_hit;

    modport master (
        output rd_en, rd_idx, up_en, up_idx, count_up, count_down, flush,
        input  rd_valid, rd_count, rd_msb, busy, sat_hit
    );

    modport slave (
        input  rd_en, rd_idx, up_en, up_idx, count_up, count_down, flush,
        output rd_valid, rd_count, rd_msb, busy, sat_hit
    );
endinterface

// File: rtl/sat_counter_table.sv
// rtl/sat_counter_table.sv - table of up/down counters with bypassed read port and flush sweep
module sat_counter_table #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int SATURATE = 1,
    parameter int INIT_VAL = 2**(WIDTH-1)-1
) (
    input  logic                 clk,
    input  logic                 reset,
    sat_counter_table_if.slave   bus
);
    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH-1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             flush_acc;
    logic             up_acc;
    logic             inc, dec;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             clamp;
    logic [WIDTH-1:0] rd_next;

    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_count_q;
    logic             sat_hit_q;

    assign busy      = (state_q == SWEEP);
    assign flush_acc = bus.flush & ~busy;
    // flush wins over a same-edge update, and nothing updates while sweeping
    assign up_acc    = bus.up_en & ~busy & ~bus.flush;
    assign inc       = bus.count_up & ~bus.count_down;
    assign dec       = bus.count_down & ~bus.count_up;
    assign cur       = mem[bus.up_idx];

    always_comb begin
        nxt   = cur;
        clamp = 1'b0;
        if (inc) begin
            if (cur == MAX && SATURATE != 0) clamp = 1'b1;
            else                            nxt   = cur + WIDTH'(1);
        end else if (dec) begin
            if (cur == '0 && SATURATE != 0) clamp = 1'b1;
            else                           nxt   = cur - WIDTH'(1);
        end
    end

    // write-first: a same-index update on this edge is what the read returns
    always_comb begin
        rd_next = mem[bus.rd_idx];
        if (busy || flush_acc)
            rd_next = INIT;
        else if (up_acc && bus.up_idx == bus.rd_idx)
            rd_next = nxt;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
        end else if (busy) begin
            mem[ptr_q] <= INIT;
        end else if (up_acc) begin
            mem[bus.up_idx] <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_count_q <= '0;
            sat_hit_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_count_q <= rd_next;
            sat_hit_q  <= up_acc & clamp;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_count = rd_count_q;
    assign bus.rd_msb   = rd_count_q[WIDTH-1];
    assign bus.busy     = busy;
    assign bus.sat_hit  = sat_hit_q;
endmodule
